sfft_bin_reader: RTL and testbench
==================================

# sfft_bin_reader

Read-side consumer of the SFFT pipeline result port. On each new valid FFT frame it sweeps the result address bus across the positive-frequency bins and captures each registered real output. Each bin goes out on a valid/ready stream toward the peak/fingerprint stage. It also tracks the per-frame peak bin, which it commits when the frame completes. It sits directly downstream of SFFT_Pipeline, driving its `output_address` and consuming `SFFT_OutReal`/`OutputValid`.

## Interface
- `NFFT`, 8, FFT size, power of 2
- `FREQS`, NFFT/2, bins swept per frame
- `ADDR_W`, $clog2(NFFT), result address width (nFFT)
- `DATA_W`, 32, SFFT_OUTPUT_WIDTH, signed two's complement
- `READ_LATENCY`, 1, cycles from address change to valid `SFFT_OutReal` (range 1–4)
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `OutputValid` in 1: level, high while the pipeline result RAM holds a complete frame
- `SFFT_OutReal` in DATA_W: result at `output_address`, delayed by READ_LATENCY
- `output_address` out ADDR_W: result RAM read address
- `bin_data` out DATA_W: captured bin value (signed, unmodified)
- `bin_index` out ADDR_W: bin number of `bin_data`
- `bin_valid` out 1: stream valid
- `bin_ready` in 1: stream ready
- `frame_done` out 1: one-cycle pulse after the last bin transfers
- `peak_index` out ADDR_W: index of the largest |bin| in the last completed frame
- `peak_value` out DATA_W: |bin| at `peak_index` (unsigned magnitude)

## Operation
- FSM states and transitions:
  - IDLE → ADDR on a rising edge of `OutputValid` (registered previous value is 0, current value is 1).
  - ADDR (1 cycle) → WAIT.
  - WAIT (READ_LATENCY cycles) → PRESENT.
  - PRESENT holds until `bin_valid && bin_ready`. It then goes to ADDR with address+1, or to DONE after bin FREQS-1.
  - DONE (1 cycle) → IDLE.
- `output_address` holds the current bin from ADDR through PRESENT.
- Capture happens on the last WAIT cycle into `bin_data`/`bin_index`.
- Stream rules:
  - `bin_valid` is high only in PRESENT.
  - `bin_data`/`bin_index` stay stable while valid && !ready.
  - Valid is never withdrawn without a transfer, except on abort.
- Peak tracking:
  - mag = |SFFT_OutReal|. The most negative input saturates to 2^(DATA_W-1)-1.
  - The running max updates on strict greater-than, so on a tie the lower index wins.
  - The running max resets at frame start.
  - `peak_index`/`peak_value` commit only in DONE and otherwise hold the previous frame.
- Abort: if `OutputValid` falls in any non-IDLE state, the FSM goes to IDLE next cycle.
  - `bin_valid` drops.
  - No `frame_done`.
  - Peak outputs are unchanged.
- Re-trigger: `OutputValid` remaining high after DONE does not restart the sweep. It must go low and then high again.
- Reset mid-frame: all state is cleared immediately (asynchronous), with no partial commit.

## Timing
- Reset values:
  - `output_address` = 0
  - `bin_data` = 0
  - `bin_index` = 0
  - `bin_valid` = 0
  - `frame_done` = 0
  - `peak_index` = 0
  - `peak_value` = 0
  - FSM in IDLE; edge-detect register = 0.
- `OutputValid` rising sampled at edge N: ADDR during cycle N+1, first `bin_valid` at edge N+2+READ_LATENCY.
- With `bin_ready` held high, bin period = 2+READ_LATENCY cycles. A frame with READ_LATENCY=1 takes 3·FREQS cycles plus 1 for DONE.
- `frame_done` and the updated peak outputs appear together, one cycle after the last transfer.

## Configuration
- `SFFT_READER_PEAK_EN` defined: peak tracking logic and registers are present as described.
- `SFFT_READER_PEAK_EN` undefined: no magnitude/compare logic; `peak_index` and `peak_value` are tied to 0. Stream and `frame_done` behaviour are identical.

## Structure
- Shared package `sfft_pkg`:
  - reader state enum (IDLE, ADDR, WAIT, PRESENT, DONE)
  - `NFFT`/`FREQS`/width constants aligned to global_variables
- Sub-module `sfft_peak_tracker`: abs-saturate, compare, running max, and commit on a `commit` strobe. It is instantiated only under `SFFT_READER_PEAK_EN`.

## Test plan
- Memory model with READ_LATENCY=1 holding bins {5, −40, 17, 40}, ready held high, rise `OutputValid`:
  - expected stream is (0,5),(1,−40),(2,17),(3,40), one bin every 3 cycles
  - `frame_done` one cycle after bin 3
  - `peak_index`=1, `peak_value`=40
- Same frame with `bin_ready` low for 5 cycles while bin 2 is presented: `bin_data`=17 and `bin_index`=2 hold stable, and no bin is lost or duplicated.
- Drop `OutputValid` while bin 1 is presented: `bin_valid` falls next cycle, no `frame_done`, and the peaks keep their prior values.
- Bin value 0x80000000: magnitude = 0x7FFFFFFF and it becomes the peak.
- Hold `OutputValid` high for 40 cycles after DONE: no second sweep. Then a low→high transition starts a new frame.
- Assert `reset` low mid-WAIT: all outputs read 0 within the same cycle. After release, the next `OutputValid` rise starts from bin 0.

Source files
------------

// File: rtl/sfft_pkg.sv
// Shared definitions for the SFFT result-port reader.
// Holds the FFT geometry and output width used by the SFFT pipeline, and the
// reader FSM state encoding. Also holds the width of the read-latency
// down-counter, which is sized for latencies 1..4.
package sfft_pkg;

   localparam int SFFT_NFFT         = 8;
   localparam int SFFT_FREQS        = SFFT_NFFT / 2;
   localparam int SFFT_OUTPUT_WIDTH = 32;
   localparam int SFFT_READ_LAT     = 1;

   // Holds READ_LATENCY-1 for latencies 1..4.
   localparam int RD_CNT_W = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR    = 3'd1,
      ST_WAIT    = 3'd2,
      ST_PRESENT = 3'd3,
      ST_DONE    = 3'd4
   } rd_state_e;

endpackage

// File: rtl/sfft_peak_tracker.sv
// Per-frame peak magnitude tracker for the SFFT bin reader.
// The running maximum restarts on 'start'. It takes each 'sample' as a
// saturated magnitude and keeps the lowest index on ties. It publishes the
// result on 'commit' and otherwise holds the previously committed peak.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : frame start, clears running max
//   sample           : sample_data/sample_index are a captured bin
//   commit           : frame complete, publish running max
//   sample_data      : signed bin value
//   sample_index     : bin number
//   peak_index/value : committed peak (value is unsigned magnitude)
module sfft_peak_tracker
   import sfft_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int DATA_W = SFFT_OUTPUT_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              sample,
   input  logic              commit,
   input  logic [DATA_W-1:0] sample_data,
   input  logic [ADDR_W-1:0] sample_index,
   output logic [ADDR_W-1:0] peak_index,
   output logic [DATA_W-1:0] peak_value
);

   localparam logic [DATA_W-1:0] MAG_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

   logic [DATA_W-1:0] mag;
   logic [DATA_W-1:0] max_val_q, max_val_d;
   logic [ADDR_W-1:0] max_idx_q, max_idx_d;
   logic [DATA_W-1:0] peak_value_q, peak_value_d;
   logic [ADDR_W-1:0] peak_index_q, peak_index_d;

   // Two's complement of the most negative value does not fit, so clamp it.
   always_comb begin
      if (!sample_data[DATA_W-1]) begin
         mag = sample_data;
      end else if (sample_data == MOST_NEG) begin
         mag = MAG_MAX;
      end else begin
         mag = ~sample_data + {{(DATA_W-1){1'b0}}, 1'b1};
      end
   end

   // Starting the max at zero/index 0 gives the same result as loading bin 0
   // unconditionally: strict greater-than keeps index 0 on a zero tie.
   always_comb begin
      max_val_d    = max_val_q;
      max_idx_d    = max_idx_q;
      peak_value_d = peak_value_q;
      peak_index_d = peak_index_q;
      if (start) begin
         max_val_d = '0;
         max_idx_d = '0;
      end else if (sample && (mag > max_val_q)) begin
         max_val_d = mag;
         max_idx_d = sample_index;
      end
      if (commit) begin
         peak_value_d = max_val_q;
         peak_index_d = max_idx_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_val_q    <= '0;
         max_idx_q    <= '0;
         peak_value_q <= '0;
         peak_index_q <= '0;
      end else begin
         max_val_q    <= max_val_d;
         max_idx_q    <= max_idx_d;
         peak_value_q <= peak_value_d;
         peak_index_q <= peak_index_d;
      end
   end

   assign peak_index = peak_index_q;
   assign peak_value = peak_value_q;

endmodule

// File: rtl/sfft_bin_reader.sv
// Read-side consumer of the SFFT pipeline result port.
// On a rising edge of OutputValid the reader sweeps output_address over bins
// 0..FREQS-1. It captures each registered real result and offers it on a
// valid/ready stream. frame_done pulses one cycle after the last transfer.
// If OutputValid drops mid-frame, the sweep is aborted silently.
// Build option: define SFFT_READER_PEAK_EN to include per-frame peak tracking.
// When it is not defined, peak_index and peak_value are tied to 0.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   OutputValid           : pipeline result RAM holds a complete frame
//   SFFT_OutReal          : result at output_address, READ_LATENCY later
//   output_address        : result RAM read address
//   bin_data/bin_index    : captured bin and its number
//   bin_valid/bin_ready   : stream handshake
//   frame_done            : one-cycle pulse after the last bin transfers
//   peak_index/peak_value : largest |bin| of the last completed frame
//
// state   | meaning
// IDLE    | waiting for OutputValid low->high
// ADDR    | output_address driven with the current bin
// WAIT    | READ_LATENCY cycles for the RAM, capture on the last one
// PRESENT | bin_valid high until the bin transfers
// DONE    | frame_done pulse, peak committed
module sfft_bin_reader
   import sfft_pkg::*;
#(
   parameter int NFFT         = SFFT_NFFT,
   parameter int FREQS        = NFFT / 2,
   parameter int ADDR_W       = $clog2(NFFT),
   parameter int DATA_W       = SFFT_OUTPUT_WIDTH,
   parameter int READ_LATENCY = SFFT_READ_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              OutputValid,
   input  logic [DATA_W-1:0] SFFT_OutReal,
   output logic [ADDR_W-1:0] output_address,
   output logic [DATA_W-1:0] bin_data,
   output logic [ADDR_W-1:0] bin_index,
   output logic              bin_valid,
   input  logic              bin_ready,
   output logic              frame_done,
   output logic [ADDR_W-1:0] peak_index,
   output logic [DATA_W-1:0] peak_value
);

   localparam logic [ADDR_W-1:0]   LAST_BIN = ADDR_W'(FREQS - 1);
   localparam logic [RD_CNT_W-1:0] WAIT_LD  = RD_CNT_W'(READ_LATENCY - 1);

   rd_state_e           state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [RD_CNT_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0]   bin_data_q, bin_data_d;
   logic [ADDR_W-1:0]   bin_index_q, bin_index_d;
   logic                frame_done_q, frame_done_d;
   logic                ov_q, ov_d;
   logic                ov_prev_q, ov_prev_d;

   logic ov_rise;
   logic last_bin;

   // OutputValid is sampled once, then compared with its previous sample.
   assign ov_rise  = ov_q && !ov_prev_q;
   assign last_bin = (addr_q == LAST_BIN);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      bin_data_d   = bin_data_q;
      bin_index_d  = bin_index_q;
      frame_done_d = 1'b0;
      ov_d         = OutputValid;
      ov_prev_d    = ov_q;

      // Abort reacts to the live level so bin_valid drops on the next edge.
      if ((state_q != ST_IDLE) && !OutputValid) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ov_rise) begin
                  state_d = ST_ADDR;
                  addr_d  = '0;
               end
            end
            ST_ADDR: begin
               state_d = ST_WAIT;
               cnt_d   = WAIT_LD;
            end
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  state_d     = ST_PRESENT;
                  bin_data_d  = SFFT_OutReal;
                  bin_index_d = addr_q;
               end else begin
                  cnt_d = cnt_q - RD_CNT_W'(1);
               end
            end
            ST_PRESENT: begin
               if (bin_ready) begin
                  if (last_bin) begin
                     state_d      = ST_DONE;
                     frame_done_d = 1'b1;
                  end else begin
                     state_d = ST_ADDR;
                     addr_d  = addr_q + ADDR_W'(1);
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         cnt_q        <= '0;
         bin_data_q   <= '0;
         bin_index_q  <= '0;
         frame_done_q <= 1'b0;
         ov_q         <= 1'b0;
         ov_prev_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         bin_data_q   <= bin_data_d;
         bin_index_q  <= bin_index_d;
         frame_done_q <= frame_done_d;
         ov_q         <= ov_d;
         ov_prev_q    <= ov_prev_d;
      end
   end

   assign output_address = addr_q;
   assign bin_data       = bin_data_q;
   assign bin_index      = bin_index_q;
   assign bin_valid      = (state_q == ST_PRESENT);
   assign frame_done     = frame_done_q;

`ifdef SFFT_READER_PEAK_EN
   logic pk_start;
   logic pk_sample;
   logic pk_commit;

   // Same conditions as the IDLE->ADDR, WAIT->PRESENT and PRESENT->DONE
   // transitions above, none of which fire while aborting.
   assign pk_start  = (state_q == ST_IDLE) && ov_rise;
   assign pk_sample = (state_q == ST_WAIT) && (cnt_q == '0) && OutputValid;
   assign pk_commit = (state_q == ST_PRESENT) && bin_ready && last_bin && OutputValid;

   sfft_peak_tracker #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_peak (
      .clk          (clk),
      .rst_n        (reset),
      .start        (pk_start),
      .sample       (pk_sample),
      .commit       (pk_commit),
      .sample_data  (SFFT_OutReal),
      .sample_index (addr_q),
      .peak_index   (peak_index),
      .peak_value   (peak_value)
   );
`else
   assign peak_index = '0;
   assign peak_value = '0;
`endif

endmodule

// File: tb/tb_sfft_bin_reader.sv
module tb_sfft_bin_reader;

   localparam int FREQS = 4;

`ifdef SFFT_READER_PEAK_EN
   localparam bit PEAK_EN = 1'b1;
`else
   localparam bit PEAK_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        OutputValid;
   logic [31:0] SFFT_OutReal;
   logic [2:0]  output_address;
   logic [31:0] bin_data;
   logic [2:0]  bin_index;
   logic        bin_valid;
   logic        bin_ready;
   logic        frame_done;
   logic [2:0]  peak_index;
   logic [31:0] peak_value;

   sfft_bin_reader dut (
      .clk            (clk),
      .reset          (reset),
      .OutputValid    (OutputValid),
      .SFFT_OutReal   (SFFT_OutReal),
      .output_address (output_address),
      .bin_data       (bin_data),
      .bin_index      (bin_index),
      .bin_valid      (bin_valid),
      .bin_ready      (bin_ready),
      .frame_done     (frame_done),
      .peak_index     (peak_index),
      .peak_value     (peak_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Result RAM with one cycle of read latency.
   logic [31:0] mem [8];
   always @(posedge clk) SFFT_OutReal <= mem[output_address];

   typedef struct {
      int          idx;
      logic [31:0] data;
   } bin_t;

   int n_checks = 0;
   int n_fail   = 0;

   bin_t        exp_q[$];
   bit          exp_done;
   bit          hold_pend;
   bit          ov_prev;
   int          frame_pk_idx;
   logic [31:0] frame_pk_val;
   int          pk_idx;
   logic [31:0] pk_val;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] sat_mag(input logic [31:0] v);
      longint s;
      s = longint'($signed(v));
      if (s < 0) s = -s;
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      return 32'(s);
   endfunction

   // Frame-level model: a new frame is the whole bin list plus its peak.
   task automatic load_frame();
      logic [31:0] m;
      exp_q.delete();
      frame_pk_idx = 0;
      frame_pk_val = 0;
      for (int i = 0; i < FREQS; i++) begin
         bin_t b;
         b.idx  = i;
         b.data = mem[i];
         exp_q.push_back(b);
         m = sat_mag(mem[i]);
         if (i == 0 || m > frame_pk_val) begin
            frame_pk_val = m;
            frame_pk_idx = i;
         end
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!reset) begin
            exp_q.delete();
            exp_done  = 0;
            hold_pend = 0;
            ov_prev   = 0;
            pk_idx    = 0;
            pk_val    = 0;
         end else begin
            check("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
            check("peak_index", {29'd0, peak_index}, PEAK_EN ? 32'(pk_idx) : 32'd0);
            check("peak_value", peak_value, PEAK_EN ? pk_val : 32'd0);
            if (hold_pend) check("valid_held", {31'd0, bin_valid}, 32'd1);
            if (bin_valid) begin
               if (exp_q.size() == 0) begin
                  check("spurious_bin_valid", {31'd0, bin_valid}, 32'd0);
               end else begin
                  check("bin_index", {29'd0, bin_index}, 32'(exp_q[0].idx));
                  check("bin_data", bin_data, exp_q[0].data);
               end
            end
            exp_done  = 0;
            hold_pend = 0;
            if (!OutputValid) begin
               exp_q.delete();
            end else if (!ov_prev) begin
               load_frame();
            end else if (bin_valid && exp_q.size() > 0) begin
               if (bin_ready) begin
                  bin_t b;
                  b = exp_q.pop_front();
                  if (b.idx == FREQS - 1) begin
                     exp_done = 1;
                     pk_idx   = frame_pk_idx;
                     pk_val   = frame_pk_val;
                  end
               end else begin
                  hold_pend = 1;
               end
            end
            ov_prev = OutputValid;
         end
      end
   endtask

   task automatic start_frame();
      @(posedge clk);
      #1 OutputValid = 1'b1;
   endtask

   task automatic wait_bin(input int idx, output int cycles);
      cycles = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         #1 cycles++;
         if (bin_valid && bin_index == 3'(idx)) return;
      end
      check("timeout_wait_bin", 32'd0, 32'd1);
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         #1 cycles++;
         if (frame_done) return;
      end
      check("timeout_wait_done", 32'd0, 32'd1);
   endtask

   task automatic set_mem(input logic [31:0] a, b, c, d);
      mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_addr"},  {29'd0, output_address}, 32'd0);
      check({tag, "_data"},  bin_data, 32'd0);
      check({tag, "_index"}, {29'd0, bin_index}, 32'd0);
      check({tag, "_valid"}, {31'd0, bin_valid}, 32'd0);
      check({tag, "_done"},  {31'd0, frame_done}, 32'd0);
      check({tag, "_pkidx"}, {29'd0, peak_index}, 32'd0);
      check({tag, "_pkval"}, peak_value, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int vcount;
      reset       = 1'b0;
      OutputValid = 1'b0;
      bin_ready   = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = 32'h0000_0063;
      set_mem(32'd5, -32'sd40, 32'd17, 32'd40);
      exp_done = 0; hold_pend = 0; ov_prev = 0; pk_idx = 0; pk_val = 0;
      frame_pk_idx = 0; frame_pk_val = 0;
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");
      reset = 1'b1;
      bin_ready = 1'b1;
      repeat (2) @(posedge clk);

      // Frame 1: latency to first bin and frame length, ready held high.
      start_frame();
      wait_bin(0, cyc);
      check("first_valid_latency", 32'(cyc), 32'd4);
      check("first_bin_data", bin_data, 32'd5);
      wait_done(cyc);
      check("valid_to_done_cycles", 32'(cyc), 32'd10);
      check("f1_peak_index", {29'd0, peak_index}, PEAK_EN ? 32'd1 : 32'd0);
      check("f1_peak_value", peak_value, PEAK_EN ? 32'd40 : 32'd0);
      #1 OutputValid = 1'b0;
      repeat (2) @(posedge clk);

      // Frame 2: back-pressure on bin 2.
      start_frame();
      wait_bin(2, cyc);
      bin_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1 check("stall_valid", {31'd0, bin_valid}, 32'd1);
      check("stall_data", bin_data, 32'd17);
      check("stall_index", {29'd0, bin_index}, 32'd2);
      bin_ready = 1'b1;
      wait_done(cyc);
      check("f2_peak_value", peak_value, PEAK_EN ? 32'd40 : 32'd0);
      #1 OutputValid = 1'b0;
      repeat (2) @(posedge clk);

      // Frame 3: aborted while bin 1 is presented.
      set_mem(-32'sd7, 32'd3, 32'd100, 32'd2);
      #1 start_frame();
      wait_bin(1, cyc);
      bin_ready   = 1'b0;
      OutputValid = 1'b0;
      @(posedge clk);
      #1 check("abort_valid_drop", {31'd0, bin_valid}, 32'd0);
      repeat (10) @(posedge clk);
      #1 check("abort_peak_index", {29'd0, peak_index}, PEAK_EN ? 32'd1 : 32'd0);
      check("abort_peak_value", peak_value, PEAK_EN ? 32'd40 : 32'd0);
      bin_ready = 1'b1;

      // Frame 4: most negative value saturates; equal magnitudes keep index 1.
      set_mem(32'd100, 32'h8000_0000, 32'h8000_0001, 32'h7FFF_FFFF);
      start_frame();
      wait_done(cyc);
      check("sat_peak_index", {29'd0, peak_index}, PEAK_EN ? 32'd1 : 32'd0);
      check("sat_peak_value", peak_value, PEAK_EN ? 32'h7FFF_FFFF : 32'd0);

      // OutputValid stays high: no new sweep.
      vcount = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1 if (bin_valid) vcount++;
      end
      check("no_retrigger_valids", 32'(vcount), 32'd0);
      OutputValid = 1'b0;
      set_mem(32'd9, 32'd8, 32'd7, 32'd6);
      repeat (2) @(posedge clk);

      // Frame 5: re-trigger after low, then reset during the bin 1 WAIT.
      start_frame();
      wait_bin(0, cyc);
      check("retrigger_first_data", bin_data, 32'd9);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      OutputValid = 1'b0;
      #1 check_all_zero("midframe_reset");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      set_mem(32'd0, 32'd0, -32'sd3, 32'd3);
      repeat (2) @(posedge clk);

      // Frame 6: starts from bin 0 after reset; zero bins and a tie at 3.
      start_frame();
      wait_bin(0, cyc);
      check("post_reset_first_index", {29'd0, bin_index}, 32'd0);
      check("post_reset_first_latency", 32'(cyc), 32'd4);
      wait_done(cyc);
      check("f6_peak_index", {29'd0, peak_index}, PEAK_EN ? 32'd2 : 32'd0);
      check("f6_peak_value", peak_value, PEAK_EN ? 32'd3 : 32'd0);
      #1 OutputValid = 1'b0;
      repeat (4) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
